// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, drives the IM read port and holds fetched words in a
// valid/ready IF register. Optional fetch-address checking is enabled by FETCH_ADDR_CHECK_EN.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET    = 32'h0000_3000,
  parameter int unsigned IM_ROM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic        if_fault
);

  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_J  = 2'b10;
  localparam logic [1:0] OP_JR = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;

  logic        accept_c;
  logic        advance_c;
  logic        redirect_c;
  logic [31:0] pc_plus4_c;
  logic [31:0] br_target_c;
  logic [31:0] j_target_c;
  logic [31:0] target_c;

  assign im_pc = pc;

  // Handshake qualifiers; redirect requests only count when decode consumes the word.
  assign accept_c    = if_valid & if_ready;
  assign advance_c   = ~if_valid | if_ready;
  assign redirect_c  = accept_c & ((npc_op == OP_JR) | (npc_op == OP_J) |
                                   ((npc_op == OP_BR) & br_taken));

  // Redirect targets are relative to the instruction being consumed, not the fetch PC.
  assign pc_plus4_c  = pc + 32'd4;
  assign br_target_c = if_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target_c  = {if_pc[31:28], imm26, 2'b00};

  always_comb begin
    target_c = jr_target;
    case (npc_op)
      OP_BR:   target_c = br_target_c;
      OP_J:    target_c = j_target_c;
      default: target_c = jr_target;
    endcase
  end

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [32:0] WIN_LO = {1'b0, PC_RESET};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_ROM_SIZE) * 33'd4);

  logic fault_q;
  logic pc_legal_c;

  // Window compare in 33 bits so a window ending at 4 GiB does not wrap.
  assign pc_legal_c = (pc[1:0] == 2'b00) && ({1'b0, pc} >= WIN_LO) && ({1'b0, pc} < WIN_HI);
  assign if_fault   = fault_q;
`else
  assign if_fault   = 1'b0;
`endif

  // State, PC and IF output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      pc       <= PC_RESET;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
`ifdef FETCH_ADDR_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect_c) begin
            pc       <= target_c;
            if_valid <= 1'b0;
          end else if (advance_c) begin
`ifdef FETCH_ADDR_CHECK_EN
            if (!pc_legal_c) begin
              // Hand a nop tagged with the bad PC to decode, then freeze.
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= 32'h0;
              fault_q  <= 1'b1;
              state    <= ST_FAULT;
            end else
`endif
            begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= im_instr;
              pc       <= pc_plus4_c;
            end
          end
        end
        ST_FAULT: begin
          if (accept_c) begin
            if_valid <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a random run scored against an
// architectural model of the accepted instruction stream.
module tb_ifu_fetch;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_target;
  logic        if_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // IM contents: a fixed scramble of the address, so every word is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign im_instr = mem_word(im_pc);

  ifu_fetch #(.PC_RESET(BASE), .IM_ROM_SIZE(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .im_pc     (im_pc),
    .im_instr  (im_instr),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .imm16     (imm16),
    .imm26     (imm26),
    .jr_target (jr_target),
    .if_fault  (if_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    npc_op    = 2'b00;
    br_taken  = 1'b0;
    imm16     = 16'h0;
    imm26     = 26'h0;
    jr_target = 32'h0;
  endtask

  task automatic run_to(input logic [31:0] pc);
    int n = 0;
    if_ready = 1'b1;
    idle_inputs();
    while (!(if_valid && if_pc == pc) && n < 300) begin
      step();
      n++;
    end
    check("run_to", if_pc, pc);
  endtask

  // Random-phase model: the architectural address of the next instruction decode must see.
  logic [31:0] exp_next;
  logic        prev_stall, prev_redirect;
  logic [31:0] prev_pc, prev_ins;
  logic [31:0] t;
  logic        redir;
  int          d;

  initial begin
    reset = 1'b0;
    if_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_fault", 32'(if_fault), 32'd0);
    check("rst_im_pc", im_pc, BASE);

    // Straight-line fetch, one word per edge.
    reset = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("seq_pc", if_pc, BASE + 32'(4 * i));
      check("seq_instr", if_instr, mem_word(BASE + 32'(4 * i)));
      check("seq_valid", 32'(if_valid), 32'd1);
    end

    // Stall holds everything.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", if_pc, 32'h3008);
      check("stall_instr", if_instr, mem_word(32'h3008));
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_im_pc", im_pc, 32'h300C);
    end
    if_ready = 1'b1;
    step();
    check("unstall_pc", if_pc, 32'h300C);

    // Taken branch back by 4 words: one bubble, then target.
    run_to(32'h3010);
    npc_op = 2'b01; br_taken = 1'b1; imm16 = 16'hFFFC;
    step();
    check("br_im_pc", im_pc, 32'h3004);
    check("br_bubble", 32'(if_valid), 32'd0);
    idle_inputs();
    step();
    check("br_target", if_pc, 32'h3004);
    check("br_tvalid", 32'(if_valid), 32'd1);

    // Not-taken branch: no bubble.
    run_to(32'h3010);
    npc_op = 2'b01; br_taken = 1'b0; imm16 = 16'hFFFC;
    step();
    check("nt_valid", 32'(if_valid), 32'd1);
    check("nt_pc", if_pc, 32'h3014);

    // j and jr.
    run_to(32'h3020);
    npc_op = 2'b10; imm26 = 26'h0000C40;
    step();
    check("j_bubble", 32'(if_valid), 32'd0);
    idle_inputs();
    step();
    check("j_target", if_pc, 32'h3100);
    npc_op = 2'b11; jr_target = 32'h3200;
    step();
    check("jr_bubble", 32'(if_valid), 32'd0);
    idle_inputs();
    step();
    check("jr_target", if_pc, 32'h3200);

    // Redirect without accept is ignored.
    if_ready = 1'b0;
    npc_op = 2'b11; jr_target = 32'h5000;
    step();
    check("noacc_im_pc", im_pc, 32'h3204);
    check("noacc_if_pc", if_pc, 32'h3200);
    check("noacc_valid", 32'(if_valid), 32'd1);
    idle_inputs();

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b0;
    #1;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_im_pc", im_pc, BASE);
    @(negedge clk);
    reset = 1'b1;
    if_ready = 1'b1;

    // Misaligned jr target.
    run_to(32'h3004);
    npc_op = 2'b11; jr_target = 32'h3002;
    step();
    check("mis_bubble", 32'(if_valid), 32'd0);
    check("mis_im_pc", im_pc, 32'h3002);
    idle_inputs();
    step();
    check("mis_if_pc", if_pc, 32'h3002);
    check("mis_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_ADDR_CHECK_EN
    check("mis_fault", 32'(if_fault), 32'd1);
    check("mis_instr", if_instr, 32'h0);
    npc_op = 2'b11; jr_target = 32'h4000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_im_pc", im_pc, 32'h3002);
      check("frz_valid", 32'(if_valid), 32'd0);
      check("frz_fault", 32'(if_fault), 32'd1);
    end
    idle_inputs();
`else
    check("mis_fault", 32'(if_fault), 32'd0);
    check("mis_instr", if_instr, mem_word(32'h3002));
    for (int i = 0; i < 5; i++) begin
      step();
      check("nofault", 32'(if_fault), 32'd0);
    end
`endif

    // Random phase.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_next = BASE;
    prev_stall = 1'b0;
    prev_redirect = 1'b0;
    prev_pc = 32'h0;
    prev_ins = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) begin
        if (prev_stall) begin
          check("r_hold_pc", if_pc, prev_pc);
          check("r_hold_instr", if_instr, prev_ins);
          check("r_hold_valid", 32'(if_valid), 32'd1);
        end else if (prev_redirect) begin
          check("r_bubble", 32'(if_valid), 32'd0);
        end else begin
          check("r_fill", 32'(if_valid), 32'd1);
        end
      end
      if (if_valid) begin
        check("r_instr", if_instr, mem_word(if_pc));
        check("r_im_pc", im_pc, if_pc + 32'd4);
      end
      check("r_fault", 32'(if_fault), 32'd0);

      if_ready  = ($urandom_range(0, 3) != 0);
      npc_op    = 2'($urandom_range(0, 3));
      br_taken  = 1'($urandom_range(0, 1));
      imm16     = 16'($urandom);
      imm26     = 26'($urandom);
      jr_target = $urandom;
      if (if_valid && if_pc >= BASE + 32'h3F00) begin
        if_ready = 1'b1;
        npc_op = 2'b11;
      end
      redir = 1'b0;
      if (if_valid && if_ready) begin
        check("r_order", if_pc, exp_next);
        t = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        redir = npc_op[1] | (npc_op == 2'b01 && br_taken);
        case (npc_op)
          2'b01: begin
            d = int'(t) - int'(if_pc + 32'd4);
            imm16 = 16'(d / 4);
          end
          2'b10: imm26 = 26'(t >> 2);
          2'b11: jr_target = t;
          default: ;
        endcase
        exp_next = redir ? t : if_pc + 32'd4;
      end
      prev_stall    = if_valid & ~if_ready;
      prev_redirect = redir;
      prev_pc       = if_pc;
      prev_ins      = if_instr;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
